debounce_in8: RTL and testbench

//  Conditions 8 raw asynchronous inputs (DIP switches / push buttons) into a clean, glitch-free bus.
//  Per bit: synchronizes to clk, then debounces.
//  db_out feeds the 8-bit inverter stage directly, and from there the LED bank.

---
 rtl/debounce_in8.sv | 116 +++++++++++
 tb/tb_debounce_in8.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_in8.sv
// Per-channel synchronizer and debouncer for raw switch/button pins.
// Each bit is synchronized and then accepted only after it has stayed at the new level long enough.
module debounce_in8 #(
   parameter int               WIDTH           = 8,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 1000000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] db_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } state_t;

   logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
   logic [WIDTH-1:0] s;

   state_t           state_p1 [WIDTH];
   state_t           state_nxt [WIDTH];
   logic [CNT_W-1:0] cnt_p1 [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] db_nxt;
   logic [WIDTH-1:0] rise_nxt;
   logic [WIDTH-1:0] fall_nxt;

   // The count only ever climbs to CNT_MAX; holding there keeps it from wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Stage p0: synchronizer chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= RESET_VAL;
      end else begin
         sync_p0[0] <= raw_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      end
   end

   assign s = sync_p0[SYNC_STAGES-1];

   always_comb begin
      db_nxt   = db_out;
      rise_nxt = '0;
      fall_nxt = '0;
      for (int b = 0; b < WIDTH; b++) begin
         state_nxt[b] = state_p1[b];
         cnt_nxt[b]   = cnt_p1[b];
         case (state_p1[b])
            STABLE: begin
               if (s[b] != db_out[b]) begin
                  state_nxt[b] = COUNTING;
                  cnt_nxt[b]   = CNT_W'(1);
               end else begin
                  cnt_nxt[b] = '0;
               end
            end
            COUNTING: begin
               if (s[b] == db_out[b]) begin
                  state_nxt[b] = STABLE;
                  cnt_nxt[b]   = '0;
               end else if (cnt_p1[b] >= CNT_MAX) begin
                  // One more mismatching sample after a full count commits the new level.
                  state_nxt[b] = STABLE;
                  cnt_nxt[b]   = '0;
                  db_nxt[b]    = s[b];
                  rise_nxt[b]  = s[b];
                  fall_nxt[b]  = ~s[b];
               end else begin
                  cnt_nxt[b] = sat_inc(cnt_p1[b]);
               end
            end
            default: begin
               state_nxt[b] = STABLE;
               cnt_nxt[b]   = '0;
            end
         endcase
      end
   end

   // Stage p1: debounce state, stable level and edge pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < WIDTH; b++) begin
            state_p1[b] <= STABLE;
            cnt_p1[b]   <= '0;
         end
         db_out  <= RESET_VAL;
         rise    <= '0;
         fall    <= '0;
         changed <= 1'b0;
      end else begin
         for (int b = 0; b < WIDTH; b++) begin
            state_p1[b] <= state_nxt[b];
            cnt_p1[b]   <= cnt_nxt[b];
         end
         db_out  <= db_nxt;
         rise    <= rise_nxt;
         fall    <= fall_nxt;
         changed <= |(rise_nxt | fall_nxt);
      end
   end

endmodule

// File: tb/tb_debounce_in8.sv
// Directed bench for debounce_in8 with a run-length reference model checked every cycle.
// Literal checks pin the latency, glitch rejection, bounce and reset scenarios.
module tb_debounce_in8;

   localparam int         WIDTH = 8;
   localparam int         SS    = 2;
   localparam int         DC    = 4;
   localparam logic [7:0] RV    = 8'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] raw_in = 8'hFF;
   logic [7:0] db_out, rise, fall;
   logic       changed;

   int n_checks = 0;
   int n_fail   = 0;

   debounce_in8 #(
      .WIDTH(WIDTH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .rst(rst), .raw_in(raw_in),
      .db_out(db_out), .rise(rise), .fall(fall), .changed(changed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: delay raw_in by SS samples, then a bit's level flips once it has
   // disagreed with the accepted level for DC+1 consecutive samples.
   logic [7:0] m_hist [SS];
   logic [7:0] m_db, m_rise, m_fall, m_s;
   logic       m_chg;
   int         m_run [WIDTH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SS; i++) m_hist[i] = RV;
         for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
         m_db   = RV;
         m_rise = '0;
         m_fall = '0;
         m_chg  = 1'b0;
      end else begin
         m_s    = m_hist[SS-1];
         m_rise = '0;
         m_fall = '0;
         for (int b = 0; b < WIDTH; b++) begin
            if (m_s[b] !== m_db[b]) begin
               m_run[b] = m_run[b] + 1;
               if (m_run[b] > DC) begin
                  m_db[b] = m_s[b];
                  if (m_s[b]) m_rise[b] = 1'b1;
                  else        m_fall[b] = 1'b1;
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_chg = |(m_rise | m_fall);
         for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = raw_in;
      end
   end

   always @(negedge clk) begin
      chk("model db_out", db_out, m_db);
      chk("model rise", rise, m_rise);
      chk("model fall", fall, m_fall);
      chk("model changed", {7'd0, changed}, {7'd0, m_chg});
   end

   int rise_cnt [WIDTH];
   int fall_cnt [WIDTH];
   initial for (int b = 0; b < WIDTH; b++) begin rise_cnt[b] = 0; fall_cnt[b] = 0; end
   always @(negedge clk) begin
      for (int b = 0; b < WIDTH; b++) begin
         if (rise[b] === 1'b1) rise_cnt[b]++;
         if (fall[b] === 1'b1) fall_cnt[b]++;
      end
   end

   task automatic drive(input logic [7:0] v);
      @(posedge clk);
      #2 raw_in = v;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, f0, r5;

      // 1: reset with all inputs high, then release
      rst = 1'b1;
      raw_in = 8'hFF;
      wait_edges(3);
      #1 chk("reset db_out", db_out, 8'h00);
      chk("reset rise", rise, 8'h00);
      chk("reset changed", {7'd0, changed}, 8'h00);
      @(posedge clk);
      #2 rst = 1'b0;
      wait_edges(6);
      #1 chk("t1 db_out before edge 7", db_out, 8'h00);
      @(posedge clk);
      #1 chk("t1 db_out at edge 7", db_out, 8'hFF);
      chk("t1 rise", rise, 8'hFF);
      chk("t1 changed", {7'd0, changed}, 8'h01);
      @(posedge clk);
      #1 chk("t1 rise cleared", rise, 8'h00);
      chk("t1 changed cleared", {7'd0, changed}, 8'h00);

      // 2: clean step on bit 3
      drive(8'h00);
      wait_edges(10);
      #1 chk("t2 settled low", db_out, 8'h00);
      drive(8'h08);
      wait_edges(6);
      #1 chk("t2 db_out before edge 7", db_out, 8'h00);
      @(posedge clk);
      #1 chk("t2 db_out at edge 7", db_out, 8'h08);
      chk("t2 rise", rise, 8'h08);
      @(posedge clk);
      #1 chk("t2 rise cleared", rise, 8'h00);

      // 3: 4-sample pulse on bit 0 is rejected, 5-sample pulse is accepted
      r0 = rise_cnt[0];
      f0 = fall_cnt[0];
      drive(8'h09);
      wait_edges(3);
      drive(8'h08);
      wait_edges(12);
      #1 chk("t3 short pulse db_out", db_out, 8'h08);
      chk("t3 short pulse rise count", 8'(rise_cnt[0] - r0), 8'd0);
      chk("t3 short pulse fall count", 8'(fall_cnt[0] - f0), 8'd0);
      r0 = rise_cnt[0];
      f0 = fall_cnt[0];
      drive(8'h09);
      wait_edges(4);
      drive(8'h08);
      wait_edges(3);
      #1 chk("t3 long pulse accepted", db_out, 8'h09);
      wait_edges(9);
      #1 chk("t3 long pulse returns", db_out, 8'h08);
      chk("t3 long pulse rise count", 8'(rise_cnt[0] - r0), 8'd1);
      chk("t3 long pulse fall count", 8'(fall_cnt[0] - f0), 8'd1);

      // 4: bounce on bit 5, then steady high
      r5 = rise_cnt[5];
      drive(8'h28);
      drive(8'h08);
      drive(8'h28);
      drive(8'h28);
      drive(8'h08);
      drive(8'h28);
      wait_edges(6);
      #1 chk("t4 db_out before settle", db_out, 8'h08);
      @(posedge clk);
      #1 chk("t4 db_out after settle", db_out, 8'h28);
      wait_edges(8);
      #1 chk("t4 single rise", 8'(rise_cnt[5] - r5), 8'd1);

      // 5: multi-bit simultaneous transitions
      drive(8'h00);
      wait_edges(10);
      drive(8'hA5);
      wait_edges(6);
      @(posedge clk);
      #1 chk("t5 db_out A5", db_out, 8'hA5);
      chk("t5 rise A5", rise, 8'hA5);
      chk("t5 fall none", fall, 8'h00);
      chk("t5 changed", {7'd0, changed}, 8'h01);
      drive(8'h5A);
      wait_edges(6);
      @(posedge clk);
      #1 chk("t5 db_out 5A", db_out, 8'h5A);
      chk("t5 rise 5A", rise, 8'h5A);
      chk("t5 fall A5", fall, 8'hA5);

      // 6: async reset while bit 2 is mid-count
      drive(8'h5E);
      wait_edges(5);
      #1 rst = 1'b1;
      #1 chk("t6 async reset db_out", db_out, RV);
      chk("t6 async reset rise", rise, 8'h00);
      chk("t6 async reset fall", fall, 8'h00);
      wait_edges(2);
      #2 rst = 1'b0;
      wait_edges(6);
      #1 chk("t6 db_out before edge 7", db_out, 8'h00);
      @(posedge clk);
      #1 chk("t6 db_out at edge 7", db_out, 8'h5E);
      chk("t6 rise", rise, 8'h5E);
      wait_edges(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
